// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: defaults, branch opcodes,
// FSM states and flag-vector bit positions.
package branch_pkg;

    localparam int ADDR_W_DEF      = 19;
    localparam int OPC_W_DEF       = 5;
    localparam int STACK_DEPTH_DEF = 8;

    localparam logic [OPC_W_DEF-1:0] OPC_JMP  = 5'b10000;
    localparam logic [OPC_W_DEF-1:0] OPC_JEQ  = 5'b10001;
    localparam logic [OPC_W_DEF-1:0] OPC_JNE  = 5'b10010;
    localparam logic [OPC_W_DEF-1:0] OPC_JGT  = 5'b10011;
    localparam logic [OPC_W_DEF-1:0] OPC_JLT  = 5'b10100;
    localparam logic [OPC_W_DEF-1:0] OPC_JZA  = 5'b10101;
    localparam logic [OPC_W_DEF-1:0] OPC_CALL = 5'b10110;
    localparam logic [OPC_W_DEF-1:0] OPC_RET  = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // flags_q layout is {eq,gt,lt,za,zb}
    localparam int FLAG_W  = 5;
    localparam int FLAG_EQ = 4;
    localparam int FLAG_GT = 3;
    localparam int FLAG_LT = 2;
    localparam int FLAG_ZA = 1;
    localparam int FLAG_ZB = 0;

endpackage

// File: rtl/branch_resolver_ret_stack.sv
// Hardware return-address LIFO. Reset clears the pointer only; entry
// contents are don't-care until pushed.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] top
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign full      = (r_ptr == PTR_W'(DEPTH));
    assign empty     = (r_ptr == '0);
    assign w_wr_idx  = r_ptr[IDX_W-1:0];
    assign w_top_idx = w_wr_idx - IDX_W'(1);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (push && !full) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch/call/return resolver producing the next fetch PC.
// Macro FLAG_BYPASS_EN: a branch accepted in the same cycle as flag_we uses the incoming flags.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int OPC_W       = OPC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_we,
    input  logic              eq_in,
    input  logic              gt_in,
    input  logic              lt_in,
    input  logic              za_in,
    input  logic              zb_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [OPC_W-1:0]  br_opcode,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              taken,
    output logic              illegal_op,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic [4:0]        flags_q
);

    state_t              r_state, w_state_next;
    logic [FLAG_W-1:0]   r_flags;
    logic [FLAG_W-1:0]   w_flags_in;
    logic [FLAG_W-1:0]   w_flags_src;
    logic [OPC_W-1:0]    r_opc;
    logic [ADDR_W-1:0]   r_target, r_pc;
    logic                r_eq, r_gt, r_lt, r_za;
    logic                r_taken, r_illegal, r_ovf, r_unf;
    logic [ADDR_W-1:0]   r_redirect_pc;
    logic                w_accept, w_eval;
    logic                w_taken, w_illegal, w_is_call, w_is_ret;
    logic                w_push, w_pop;
    logic                w_full, w_empty;
    logic [ADDR_W-1:0]   w_top, w_pc_inc, w_next_pc;

    assign w_flags_in = {eq_in, gt_in, lt_in, za_in, zb_in};

`ifdef FLAG_BYPASS_EN
    assign w_flags_src = flag_we ? w_flags_in : r_flags;
`else
    assign w_flags_src = r_flags;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (br_valid) w_state_next = EVAL;
            EVAL:    w_state_next = RESP;
            RESP:    if (redirect_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        br_ready       = (r_state == IDLE);
        redirect_valid = (r_state == RESP);
        w_accept       = (r_state == IDLE) && br_valid;
        w_eval         = (r_state == EVAL);
        w_push         = w_eval && w_is_call && !w_full;
        w_pop          = w_eval && w_is_ret && !w_empty;
    end

    // Condition decode on the request latched at acceptance.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_is_call = 1'b0;
        w_is_ret  = 1'b0;
        case (r_opc)
            OPC_JMP:  w_taken = 1'b1;
            OPC_JEQ:  w_taken = r_eq;
            OPC_JNE:  w_taken = !r_eq;
            OPC_JGT:  w_taken = r_gt;
            OPC_JLT:  w_taken = r_lt;
            OPC_JZA:  w_taken = r_za;
            OPC_CALL: begin
                w_taken   = 1'b1;
                w_is_call = 1'b1;
            end
            OPC_RET: begin
                w_taken  = !w_empty;
                w_is_ret = 1'b1;
            end
            default:  w_illegal = 1'b1;
        endcase
    end

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_next_pc = !w_taken ? w_pc_inc : (w_is_ret ? w_top : r_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags       <= '0;
            r_opc         <= '0;
            r_target      <= '0;
            r_pc          <= '0;
            r_eq          <= 1'b0;
            r_gt          <= 1'b0;
            r_lt          <= 1'b0;
            r_za          <= 1'b0;
            r_taken       <= 1'b0;
            r_illegal     <= 1'b0;
            r_redirect_pc <= '0;
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
        end else begin
            if (flag_we) begin
                r_flags <= w_flags_in;
            end
            if (w_accept) begin
                r_opc    <= br_opcode;
                r_target <= br_target;
                r_pc     <= br_pc;
                r_eq     <= w_flags_src[FLAG_EQ];
                r_gt     <= w_flags_src[FLAG_GT];
                r_lt     <= w_flags_src[FLAG_LT];
                r_za     <= w_flags_src[FLAG_ZA];
            end
            if (w_eval) begin
                r_taken       <= w_taken;
                r_illegal     <= w_illegal;
                r_redirect_pc <= w_next_pc;
                if (w_is_call && w_full) r_ovf <= 1'b1;
                if (w_is_ret && w_empty) r_unf <= 1'b1;
            end
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .full      (w_full),
        .empty     (w_empty),
        .top       (w_top)
    );

    assign redirect_pc = r_redirect_pc;
    assign taken       = r_taken;
    assign illegal_op  = r_illegal;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;
    assign flags_q     = r_flags;

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized self-checking bench for branch_resolver against a queue-based
// behavioural model; honours FLAG_BYPASS_EN for same-cycle flag writes.
module tb_branch_resolver;

`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag_we = 1'b0;
    logic        eq_in = 1'b0, gt_in = 1'b0, lt_in = 1'b0, za_in = 1'b0, zb_in = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [4:0]  br_opcode = '0;
    logic [18:0] br_target = '0;
    logic [18:0] br_pc = '0;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [18:0] redirect_pc;
    logic        taken;
    logic        illegal_op;
    logic        stack_ovf;
    logic        stack_unf;
    logic [4:0]  flags_q;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit [18:0] m_stack[$];
    bit [4:0]  m_flags;
    bit        m_ovf, m_unf;

    branch_resolver dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .eq_in(eq_in), .gt_in(gt_in), .lt_in(lt_in), .za_in(za_in), .zb_in(zb_in),
        .br_valid(br_valid), .br_ready(br_ready), .br_opcode(br_opcode),
        .br_target(br_target), .br_pc(br_pc),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .taken(taken), .illegal_op(illegal_op),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_stack.delete();
        m_flags = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // flags given as {eq,gt,lt,za,zb}
    task automatic model_branch(input bit [4:0] opc, input bit [18:0] pc, input bit [18:0] tgt,
                                input bit [4:0] fl, output bit t, output bit [18:0] npc,
                                output bit ill);
        bit [18:0] fall;
        fall = pc + 19'd1;
        t    = 1'b0;
        ill  = 1'b0;
        npc  = fall;
        case (opc)
            5'd16: t = 1'b1;
            5'd17: t = fl[4];
            5'd18: t = !fl[4];
            5'd19: t = fl[3];
            5'd20: t = fl[2];
            5'd21: t = fl[1];
            5'd22: begin
                t = 1'b1;
                if (m_stack.size() < DEPTH) m_stack.push_back(fall);
                else m_ovf = 1'b1;
            end
            5'd23: begin
                if (m_stack.size() > 0) begin
                    t   = 1'b1;
                    npc = m_stack.pop_back();
                end else begin
                    m_unf = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (t && opc != 5'd23) npc = tgt;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_br_ready"}, br_ready, 1);
        check_val({tag, "_rv"}, redirect_valid, 0);
        check_val({tag, "_taken"}, taken, 0);
        check_val({tag, "_pc"}, redirect_pc, 0);
        check_val({tag, "_illegal"}, illegal_op, 0);
        check_val({tag, "_ovf"}, stack_ovf, 0);
        check_val({tag, "_unf"}, stack_unf, 0);
        check_val({tag, "_flags"}, flags_q, 0);
    endtask

    // Entry/exit point: 1 time unit after a rising edge.
    task automatic set_flags(input bit [4:0] fv);
        {eq_in, gt_in, lt_in, za_in, zb_in} = fv;
        flag_we = 1'b1;
        @(posedge clk);
        #1 flag_we = 1'b0;
        m_flags = fv;
        @(negedge clk);
        check_val("flags_q", flags_q, m_flags);
        @(posedge clk);
        #1;
    endtask

    task automatic run_branch(input bit [4:0] opc, input bit [18:0] pc, input bit [18:0] tgt,
                              input bit fw, input bit [4:0] fv, input int hold);
        bit        e_t, e_ill;
        bit [18:0] e_pc;
        bit [4:0]  eval_flags;
        check_val("ready_idle", br_ready, 1);
        br_valid  = 1'b1;
        br_opcode = opc;
        br_pc     = pc;
        br_target = tgt;
        flag_we   = fw;
        {eq_in, gt_in, lt_in, za_in, zb_in} = fv;
        eval_flags = (fw && BYPASS) ? fv : m_flags;
        if (fw) m_flags = fv;
        model_branch(opc, pc, tgt, eval_flags, e_t, e_pc, e_ill);
        @(posedge clk);
        #1;
        br_valid  = 1'b0;
        flag_we   = 1'b0;
        br_opcode = 5'($urandom);
        br_pc     = 19'($urandom);
        br_target = 19'($urandom);
        @(negedge clk);
        check_val("rv_eval", redirect_valid, 0);
        check_val("ready_eval", br_ready, 0);
        check_val("flags_after", flags_q, m_flags);
        @(negedge clk);
        check_val("rv_resp", redirect_valid, 1);
        check_val("taken", taken, e_t);
        check_val("redirect_pc", redirect_pc, e_pc);
        check_val("illegal", illegal_op, e_ill);
        check_val("ovf", stack_ovf, m_ovf);
        check_val("unf", stack_unf, m_unf);
        // Competing requests during backpressure must be ignored.
        for (int h = 0; h < hold; h++) begin
            br_valid  = 1'b1;
            br_opcode = 5'($urandom);
            @(negedge clk);
            check_val("hold_rv", redirect_valid, 1);
            check_val("hold_ready", br_ready, 0);
            check_val("hold_pc", redirect_pc, e_pc);
            check_val("hold_taken", taken, e_t);
        end
        redirect_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_ready = 1'b0;
        br_valid       = 1'b0;
        $display("txn opc=%b pc=%05h tgt=%05h fw=%0d -> taken=%0d pc=%05h ill=%0d ovf=%0d unf=%0d depth=%0d",
                 opc, pc, tgt, fw, e_t, e_pc, e_ill, m_ovf, m_unf, m_stack.size());
    endtask

    initial begin
        bit [4:0]  r_opc;
        bit [18:0] r_pc, r_tg;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Jump condition
        set_flags(5'b10000);
        run_branch(5'd17, 19'h00010, 19'h00100, 1'b0, 5'b0, 0);
        // Fall-through wrap
        run_branch(5'd18, 19'h7FFFF, 19'h12345, 1'b0, 5'b0, 0);
        // Nested calls
        run_branch(5'd22, 19'h00010, 19'h00200, 1'b0, 5'b0, 0);
        run_branch(5'd22, 19'h00205, 19'h00300, 1'b0, 5'b0, 0);
        run_branch(5'd23, 19'h00302, 19'h0, 1'b0, 5'b0, 0);
        run_branch(5'd23, 19'h00207, 19'h0, 1'b0, 5'b0, 0);
        // Same-cycle flag write
        set_flags(5'b00000);
        run_branch(5'd17, 19'h00040, 19'h00400, 1'b1, 5'b10000, 0);
        // Backpressure
        run_branch(5'd16, 19'h01000, 19'h02000, 1'b0, 5'b0, 5);
        // Illegal opcode
        run_branch(5'd3, 19'h00100, 19'h00500, 1'b0, 5'b0, 1);
        // Overflow: 9 calls, then drain and underflow
        for (int i = 0; i < 9; i++)
            run_branch(5'd22, 19'(i * 16), 19'(19'h1000 + i), 1'b0, 5'b0, 0);
        for (int i = 0; i < 9; i++)
            run_branch(5'd23, 19'(19'h2000 + i), 19'h0, 1'b0, 5'b0, 0);

        // Reset during EVAL
        br_valid = 1'b1; br_opcode = 5'd16; br_pc = 19'h00050; br_target = 19'h00600;
        @(posedge clk);
        #1 br_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_outputs("rst_eval");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("no_redirect_after_rst", redirect_valid, 0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                set_flags(5'($urandom));
            end else begin
                r_opc = ($urandom_range(0, 9) < 8) ? 5'(16 + $urandom_range(0, 7)) : 5'($urandom_range(0, 15));
                r_pc  = ($urandom_range(0, 15) == 0) ? 19'h7FFFF : 19'($urandom);
                r_tg  = 19'($urandom);
                run_branch(r_opc, r_pc, r_tg, ($urandom_range(0, 3) == 0), 5'($urandom),
                           $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
